// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with arbitrary depth, optional fall-through, synchronous flush,
// fill-level thresholds and sticky overflow/underflow flags.
module fifo_sync_flex #(
    parameter  int DATA_W       = 32,
    parameter  int DEPTH        = 8,
    parameter  int FALL_THROUGH = 0,
    parameter  int AF_THRESH    = DEPTH - 1,
    parameter  int AE_THRESH    = 1,
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] src_data_i,
    input  logic              src_valid_i,
    output logic              src_ready_o,
    output logic [DATA_W-1:0] dst_data_o,
    output logic              dst_valid_o,
    input  logic              dst_ready_i,
    output logic [CNT_W-1:0]  usage_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic [PTR_W-1:0]  w_wptr_next;
    logic [PTR_W-1:0]  w_rptr_next;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_bypass;
    logic              w_wr_en;
    logic              w_rd_en;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // Ready deliberately ignores dst_ready_i: no combinational path through a full FIFO.
    assign src_ready_o = ~w_full & ~flush_i;

    generate
        if (FALL_THROUGH != 0) begin : g_ft
            assign dst_valid_o = ~flush_i & (~w_empty | src_valid_i);
            assign dst_data_o  = w_empty ? src_data_i : r_mem[r_rptr];
            assign w_bypass    = w_empty & w_push & w_pop;
        end else begin : g_reg
            assign dst_valid_o = ~flush_i & ~w_empty;
            assign dst_data_o  = r_mem[r_rptr];
            assign w_bypass    = 1'b0;
        end
    endgenerate

    assign w_push  = src_valid_i & src_ready_o;
    assign w_pop   = dst_valid_o & dst_ready_i;
    // A bypassed word never touches storage, pointers or the count.
    assign w_wr_en = w_push & ~w_bypass;
    assign w_rd_en = w_pop & ~w_bypass;

    generate
        if (DEPTH == 1) begin : g_ptr_single
            assign w_wptr_next = '0;
            assign w_rptr_next = '0;
        end else begin : g_ptr_wrap
            always_comb begin
                w_wptr_next = r_wptr;
                if (w_wr_en) begin
                    w_wptr_next = (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
                end
            end

            always_comb begin
                w_rptr_next = r_rptr;
                if (w_rd_en) begin
                    w_rptr_next = (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= w_wptr_next;
            r_rptr  <= w_rptr_next;
            r_count <= w_count_next;
        end
    end

    // Storage survives flush; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_wptr] <= src_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (src_valid_i && w_full) begin
                r_overflow <= 1'b1;
            end
            if (dst_ready_i && !dst_valid_o) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign usage_o        = r_count;
    assign almost_full_o  = (32'(r_count) >= AF_THRESH);
    assign almost_empty_o = (32'(r_count) <= AE_THRESH);
    assign overflow_o     = r_overflow;
    assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Drives three FIFO configurations with shared directed + random stimulus and
// compares every output against a queue-based reference model per instance.
module tb_fifo_sync_flex;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       flush;
    logic       src_valid;
    logic       dst_ready;
    logic [7:0] src_data;

    logic       src_ready [3];
    logic       dst_valid [3];
    logic       af        [3];
    logic       ae        [3];
    logic       ovf       [3];
    logic       udf       [3];
    logic [7:0] dst_data  [3];
    logic [2:0] usage     [3];
    logic [2:0] usage_a;
    logic [2:0] usage_b;
    logic [0:0] usage_c;

    assign usage[0] = usage_a;
    assign usage[1] = usage_b;
    assign usage[2] = {2'b00, usage_c};

    int dep  [3] = '{5, 4, 1};
    int ft   [3] = '{0, 1, 0};
    int afth [3] = '{4, 3, 0};
    int aeth [3] = '{1, 1, 1};

    logic [7:0] mq [3][$];
    bit         m_ovf [3];
    bit         m_udf [3];

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] seq_data;

    fifo_sync_flex #(.DATA_W(8), .DEPTH(5), .FALL_THROUGH(0)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(src_ready[0]),
        .dst_data_o(dst_data[0]), .dst_valid_o(dst_valid[0]), .dst_ready_i(dst_ready),
        .usage_o(usage_a), .almost_full_o(af[0]), .almost_empty_o(ae[0]),
        .overflow_o(ovf[0]), .underflow_o(udf[0])
    );

    fifo_sync_flex #(.DATA_W(8), .DEPTH(4), .FALL_THROUGH(1)) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(src_ready[1]),
        .dst_data_o(dst_data[1]), .dst_valid_o(dst_valid[1]), .dst_ready_i(dst_ready),
        .usage_o(usage_b), .almost_full_o(af[1]), .almost_empty_o(ae[1]),
        .overflow_o(ovf[1]), .underflow_o(udf[1])
    );

    fifo_sync_flex #(.DATA_W(8), .DEPTH(1), .FALL_THROUGH(0)) u_c (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(src_ready[2]),
        .dst_data_o(dst_data[2]), .dst_valid_o(dst_valid[2]), .dst_ready_i(dst_ready),
        .usage_o(usage_c), .almost_full_o(af[2]), .almost_empty_o(ae[2]),
        .overflow_o(ovf[2]), .underflow_o(udf[2])
    );

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[u%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            m_ovf[k] = 1'b0;
            m_udf[k] = 1'b0;
        end
    endtask

    function automatic bit exp_ready(input int k);
        return (mq[k].size() < dep[k]) && !flush;
    endfunction

    function automatic bit exp_valid(input int k);
        return !flush && (mq[k].size() > 0 || (ft[k] != 0 && src_valid));
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < 3; k++) begin
            int n = mq[k].size();
            check("ready", k, 32'(src_ready[k]), 32'(exp_ready(k)));
            check("valid", k, 32'(dst_valid[k]), 32'(exp_valid(k)));
            check("usage", k, 32'(usage[k]), 32'(n));
            check("almost_full", k, 32'(af[k]), 32'(n >= afth[k]));
            check("almost_empty", k, 32'(ae[k]), 32'(n <= aeth[k]));
            check("overflow", k, 32'(ovf[k]), 32'(m_ovf[k]));
            check("underflow", k, 32'(udf[k]), 32'(m_udf[k]));
            if (exp_valid(k)) begin
                check("data", k, 32'(dst_data[k]), 32'((n > 0) ? mq[k][0] : src_data));
            end
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            int n     = mq[k].size();
            bit vld   = exp_valid(k);
            bit push  = src_valid && exp_ready(k);
            bit pop   = vld && dst_ready;
            if (src_valid && n == dep[k]) m_ovf[k] = 1'b1;
            if (dst_ready && !vld)        m_udf[k] = 1'b1;
            if (flush) begin
                mq[k].delete();
            end else if (!(push && pop && n == 0)) begin
                if (pop)  void'(mq[k].pop_front());
                if (push) mq[k].push_back(src_data);
            end
        end
    endtask

    // Inputs change just after a rising edge; outputs are checked on the falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
        src_valid = v;
        src_data  = d;
        dst_ready = r;
        flush     = f;
        @(negedge clk);
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_view(input string tag);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_usage"}, k, 32'(usage[k]), 32'd0);
            check({tag, "_valid"}, k, 32'(dst_valid[k]), 32'd0);
            check({tag, "_data"}, k, 32'(dst_data[k]), 32'd0);
            check({tag, "_overflow"}, k, 32'(ovf[k]), 32'd0);
            check({tag, "_underflow"}, k, 32'(udf[k]), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; src_valid = 1'b0; dst_ready = 1'b0; src_data = 8'h00;
        model_reset();
        #12;
        check_reset_view("rst");
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill past capacity, then drain past empty.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Continuous push+pop at usage 2 so the pointers wrap.
        seq_data = 8'h40;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, seq_data, 1'b0, 1'b0);
            seq_data++;
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b1, seq_data, 1'b1, 1'b0);
            seq_data++;
        end
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Fall-through bypass from empty.
        step(1'b1, 8'hAB, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Flush with both handshakes requested.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'h70, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0);
        end

        // Asynchronous reset between edges with data stored.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        src_valid = 1'b0; src_data = 8'h00; dst_ready = 1'b0; flush = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_view("async_rst");
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 100; i++) begin
            step($urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 1) != 0,
                 $urandom_range(0, 29) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flex.md
Name: fifo_sync_flex

Overview:
- Single-clock, parametrised FIFO: the same-domain successor of the team's gray-pointer CDC FIFO, for buffering inside one clock domain.
- Generalised over the CDC FIFO:
  - depth is any integer ≥ 1 (not restricted to powers of two)
  - optional fall-through (zero-latency) mode
  - synchronous flush
  - fill-level output with almost-full/almost-empty thresholds
  - sticky overflow/underflow error flags
- Sits between producer/consumer stages with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 32: payload width in bits (≥ 1).
- DEPTH, 8: number of storage entries (≥ 1, any integer).
- FALL_THROUGH, 0: 1 = data from an empty FIFO is presented combinationally at the output in the same cycle.
- AF_THRESH, DEPTH-1: almost_full_o asserts when usage ≥ AF_THRESH (0..DEPTH).
- AE_THRESH, 1: almost_empty_o asserts when usage ≤ AE_THRESH (0..DEPTH).
- CNT_W, $clog2(DEPTH+1): width of usage_o (derived, not overridden).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous clear of all contents.
- src_data_i  in  DATA_W  write payload.
- src_valid_i  in  1  producer has data.
- src_ready_o  out  1  FIFO can accept.
- dst_data_o  out  DATA_W  read payload (head entry).
- dst_valid_o  out  1  head entry valid.
- dst_ready_i  in  1  consumer accepts.
- usage_o  out  CNT_W  number of stored entries.
- almost_full_o  out  1  usage_o ≥ AF_THRESH.
- almost_empty_o  out  1  usage_o ≤ AE_THRESH.
- overflow_o  out  1  sticky: src_valid_i seen while full.
- underflow_o  out  1  sticky: dst_ready_i seen while empty, with no fall-through data.

Behaviour:
- Interface: one clock clk_i; reset rst_i is asynchronous and active-high.
- Reset (rst_i=1) state:
  - write pointer, read pointer and count = 0
  - storage = 0
  - overflow_o, underflow_o = 0
- Outputs during/after reset:
  - src_ready_o=1, dst_valid_o=0 (FT=0), dst_data_o=0, usage_o=0
  - almost_empty_o=1
  - almost_full_o=(AF_THRESH==0)
- Push = src_valid_i & src_ready_o; pop = dst_valid_o & dst_ready_i.
- src_ready_o = (count < DEPTH) & ~flush_i. It never depends on dst_ready_i, so a full FIFO does not accept push-while-pop (no combinational ready path).
- FT=0 read side:
  - dst_valid_o = (count > 0) & ~flush_i
  - dst_data_o = storage[rptr]
  - push-to-output latency is 1 cycle
- FT=1 read side:
  - With count==0, dst_valid_o=src_valid_i and dst_data_o=src_data_i.
  - If push and pop coincide while empty, the word bypasses storage; pointers and count are unchanged.
  - With count>0, behaviour is identical to FT=0.
- Pointers:
  - Each increments on its event and wraps from DEPTH-1 to 0 (explicit compare, no power-of-two masking).
  - DEPTH=1 uses a 1-bit pointer tied to 0.
- Count update:
  - +1 on push-only, -1 on pop-only.
  - Unchanged on simultaneous push and pop, or on FT bypass.
  - Never exceeds DEPTH and never goes below 0.
- Simultaneous push and pop at count==DEPTH cannot occur (ready=0). At count==0 with FT=0, no pop can occur (valid=0).
- Flush:
  - In the flush_i cycle, src_ready_o=0 and dst_valid_o=0; no push or pop takes effect.
  - Next cycle: pointers=0, count=0.
  - Storage contents and sticky flags are retained.
- Status outputs:
  - usage_o = count.
  - almost_full_o and almost_empty_o are combinational from the registered count.
- Error flags:
  - overflow_o sets when src_valid_i=1 and count==DEPTH.
  - underflow_o sets when dst_ready_i=1 and dst_valid_o=0.
  - Both clear only on rst_i.
- Reset mid-operation: immediate asynchronous return to the reset state; any in-flight handshake is discarded.

Test Plan:
- DEPTH=5, FT=0: push 0x11..0x15 back-to-back -> src_ready_o drops after 5th push, usage_o=5, almost_full_o=1 from usage 4; pop all -> order 0x11..0x15, dst_valid_o low after last.
- DEPTH=5, FT=0: 12 cycles of continuous push+pop at usage 2 -> usage_o stays 2; rptr/wptr wrap 4->0 twice; data order preserved.
- DEPTH=4, FT=1, empty: push 0xAB with dst_ready_i=1 -> dst_valid_o=1 and dst_data_o=0xAB in the same cycle; usage_o remains 0.
- DEPTH=4: fill with 3 words, assert flush_i together with src_valid_i and dst_ready_i -> that cycle ready=0 and valid=0; next cycle usage_o=0, almost_empty_o=1, no word lost/duplicated afterwards.
- Fill to DEPTH, hold src_valid_i=1 -> overflow_o=1 next cycle and sticky; pop on empty (FT=0) -> underflow_o=1; both clear only on rst_i pulse.
- Assert rst_i asynchronously (between clock edges) with usage_o=3 -> usage_o=0, dst_valid_o=0, dst_data_o=0 immediately, without waiting for an edge.
